rf_wb_arbiter: RTL

- Owns the single write port (A3/WD/RFWr) of the 32x32 register file.
- Arbitrates that port between the in-order pipeline writeback and the long-latency unit (mul/div, load-miss return).
- Keeps a per-register pending scoreboard for long-latency destinations and drives the RAW/WAW hazard signal to the issue stage.
- Sits between the WB stage, the long-latency unit and the register file.

---
 rtl/rf_wb_arbiter_pkg.sv | 13 +
 rtl/rf_wb_arbiter_if.sv | 40 ++++
 rtl/rf_wb_arbiter_scoreboard.sv | 52 +++++
 rtl/rf_wb_arbiter.sv | 70 +++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Imported by the interface, the scoreboard and the top.
package rf_wb_arbiter_pkg;
  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         NUM_REGS     = 32;
  localparam int         MAX_WAIT_DEF = 4;
  localparam int         WAIT_W_DEF   = 3;

  // One-hot register select; $0 never maps to a bit, so busy_mask[0] stays 0.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input logic [4:0] addr);
    return (en && addr != REG_ZERO) ? (NUM_REGS'(1) << addr) : '0;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback/issue bundle between the pipeline, the long-latency unit and the arbiter.
// master = request/issue side, slave = arbiter.
interface rf_wb_arbiter_if;
  logic        pipe_wr_valid;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        pipe_wr_ready;
  logic        lu_wr_valid;
  logic [4:0]  lu_wr_addr;
  logic [31:0] lu_wr_data;
  logic        lu_wr_ready;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic [4:0]  chk_a3;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;
  logic        wb_err;

  modport master (
    output pipe_wr_valid, pipe_wr_addr, pipe_wr_data,
    output lu_wr_valid, lu_wr_addr, lu_wr_data,
    output lu_issue, lu_issue_addr, chk_a1, chk_a2, chk_a3,
    input  pipe_wr_ready, lu_wr_ready, hazard,
    input  rf_we, rf_a3, rf_wd, busy_mask, pending_cnt, wb_err
  );

  modport slave (
    input  pipe_wr_valid, pipe_wr_addr, pipe_wr_data,
    input  lu_wr_valid, lu_wr_addr, lu_wr_data,
    input  lu_issue, lu_issue_addr, chk_a1, chk_a2, chk_a3,
    output pipe_wr_ready, lu_wr_ready, hazard,
    output rf_we, rf_a3, rf_wd, busy_mask, pending_cnt, wb_err
  );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard for long-latency destinations plus the
// issue-stage hazard lookup; pending count tracks popcount(busy mask).
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set_en,
  input  logic [4:0]          i_set_addr,
  input  logic                i_clr_en,
  input  logic [4:0]          i_clr_addr,
  input  logic [4:0]          i_chk_a1,
  input  logic [4:0]          i_chk_a2,
  input  logic [4:0]          i_chk_a3,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic [5:0]          o_pending_cnt,
  output logic                o_hazard,
  output logic                o_clr_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [5:0]          r_cnt;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic                w_inc;
  logic                w_dec;

  assign w_set_vec = reg_onehot(i_set_en, i_set_addr);
  assign w_clr_vec = reg_onehot(i_clr_en, i_clr_addr);

  // A set on the register being cleared wins, so that clear never decrements.
  assign w_inc = |(w_set_vec & ~r_busy);
  assign w_dec = |(w_clr_vec & r_busy & ~w_set_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 6'd1;
        2'b01:   r_cnt <= r_cnt - 6'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_busy_mask   = r_busy;
  assign o_pending_cnt = r_cnt;
  assign o_hazard      = rst_n && (r_busy[i_chk_a1] | r_busy[i_chk_a2] | r_busy[i_chk_a3]);
  assign o_clr_busy    = r_busy[i_clr_addr];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: pipeline writeback has priority, the
// long-latency unit is forced through after MAX_WAIT consecutive refusals.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_wb_arbiter_if.slave    bus
);
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_wb_err;
  logic              w_force;
  logic              w_pipe_grant;
  logic              w_lu_grant;
  logic [4:0]        w_a3;
  logic              w_clr_busy;

  assign w_force = (r_wait_cnt == WAIT_W'(MAX_WAIT));

  assign bus.pipe_wr_ready = rst_n && (bus.pipe_wr_valid ? !w_force : 1'b1);
  assign bus.lu_wr_ready   = rst_n && bus.lu_wr_valid && (w_force || !bus.pipe_wr_valid);

  assign w_pipe_grant = bus.pipe_wr_valid && bus.pipe_wr_ready;
  assign w_lu_grant   = bus.lu_wr_valid && bus.lu_wr_ready;

  // Idle port holds the pipeline values on A3/WD.
  assign w_a3      = w_lu_grant ? bus.lu_wr_addr : bus.pipe_wr_addr;
  assign bus.rf_a3 = w_a3;
  assign bus.rf_wd = w_lu_grant ? bus.lu_wr_data : bus.pipe_wr_data;
  assign bus.rf_we = rst_n && (w_pipe_grant || w_lu_grant) && (w_a3 != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!bus.lu_wr_valid || w_lu_grant) begin
      r_wait_cnt <= '0;
    end else if (!w_force) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_err <= 1'b0;
    end else if (w_lu_grant && bus.lu_wr_addr != REG_ZERO && !w_clr_busy) begin
      r_wb_err <= 1'b1;
    end
  end

  assign bus.wb_err = r_wb_err;

  rf_scoreboard u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_set_en      (bus.lu_issue),
    .i_set_addr    (bus.lu_issue_addr),
    .i_clr_en      (w_lu_grant),
    .i_clr_addr    (bus.lu_wr_addr),
    .i_chk_a1      (bus.chk_a1),
    .i_chk_a2      (bus.chk_a2),
    .i_chk_a3      (bus.chk_a3),
    .o_busy_mask   (bus.busy_mask),
    .o_pending_cnt (bus.pending_cnt),
    .o_hazard      (bus.hazard),
    .o_clr_busy    (w_clr_busy)
  );
endmodule
